// File: rtl/div_ctrl_pkg.sv
// Shared divide-op encodings, controller state encoding and small op-decode helpers.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_special_detect.sv
// Combinational detection of divide-by-zero and signed overflow with their fixed results.
module div_special_detect
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_is_special,
  output logic [XLEN-1:0] o_special_result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            w_b_zero;
  logic            w_a_min;
  logic            w_b_neg1;
  logic            w_ovf;
  logic [XLEN-1:0] w_raw;

  // Classify operands (low word only for W-ops) and pick the architectural result.
  always_comb begin
    w_b_zero     = i_word ? (i_b[31:0] == '0) : (i_b == '0);
    w_a_min      = i_word ? (i_a[31:0] == 32'h8000_0000) : (i_a == MIN_NEG);
    w_b_neg1     = i_word ? (i_b[31:0] == '1) : (i_b == '1);
    w_ovf        = op_is_signed(i_op) && w_a_min && w_b_neg1;
    o_is_special = w_b_zero || w_ovf;
    w_raw        = '0;
    if (w_b_zero) begin
      w_raw = op_is_rem(i_op) ? i_a : '1;
    end else if (w_ovf) begin
      w_raw = op_is_rem(i_op) ? '0 : i_a;
    end
  end

  // W-op results are sign-extended from bit 31; only meaningful on a wide datapath.
  generate
    if (XLEN > 32) begin : g_wide
      assign o_special_result = i_word ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
    end else begin : g_narrow
      assign o_special_result = w_raw;
    end
  endgenerate

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between the EX-stage M-extension request port and the multi-cycle div_unit.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned CACHE_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             div_start,
  output logic [1:0]       div_op,
  output logic             div_is_word,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic [XLEN-1:0]  div_result
);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [1:0]       r_op;
  logic             r_word;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_result;

  logic             r_c_valid;
  logic [1:0]       r_c_op;
  logic             r_c_word;
  logic [XLEN-1:0]  r_c_a;
  logic [XLEN-1:0]  r_c_b;
  logic [XLEN-1:0]  r_c_result;

  logic             w_req_word;
  logic             w_accept;
  logic             w_hit;
  logic             w_is_special;
  logic [XLEN-1:0]  w_special_result;
  logic [XLEN-1:0]  w_div_res_ext;
  logic             w_div_start;
  logic             w_div_done;

  assign w_req_word = (XLEN == 64) ? req_word : 1'b0;
  assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
  assign w_hit      = (CACHE_EN != 0) && r_c_valid && (r_c_op == req_op) &&
                      (r_c_word == w_req_word) && (r_c_a == req_a) && (r_c_b == req_b);
  assign w_div_done = (r_state == S_WAIT) && div_ready && !flush;

  div_special_detect #(.XLEN(XLEN)) u_special (
    .i_op             (req_op),
    .i_word           (w_req_word),
    .i_a              (req_a),
    .i_b              (req_b),
    .o_is_special     (w_is_special),
    .o_special_result (w_special_result)
  );

  generate
    if (XLEN > 32) begin : g_wide
      assign w_div_res_ext = r_word ? {{(XLEN-32){div_result[31]}}, div_result[31:0]} : div_result;
    end else begin : g_narrow
      assign w_div_res_ext = div_result;
    end
  endgenerate

  // Next-state and start-pulse decode.
  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (w_is_special || w_hit) ? S_RESP : S_START;
      end
      S_START: begin
        if (flush) begin
          w_next = S_IDLE;
        end else if (!div_busy) begin
          w_div_start = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving with the flush is simply discarded; no drain needed.
        if (flush)          w_next = div_ready ? S_IDLE : S_DRAIN;
        else if (div_ready) w_next = S_RESP;
      end
      S_DRAIN: begin
        if (div_ready) w_next = S_IDLE;
      end
      S_RESP: begin
        if (flush || rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, request capture, result latch and one-entry result cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_word     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_tag      <= '0;
      r_result   <= '0;
      r_c_valid  <= 1'b0;
      r_c_op     <= '0;
      r_c_word   <= 1'b0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_c_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= req_op;
        r_word <= w_req_word;
        r_a    <= req_a;
        r_b    <= req_b;
        r_tag  <= req_tag;
        if (w_is_special) r_result <= w_special_result;
        else if (w_hit)   r_result <= r_c_result;
      end
      if (w_div_done) begin
        r_result   <= w_div_res_ext;
        r_c_valid  <= 1'b1;
        r_c_op     <= r_op;
        r_c_word   <= r_word;
        r_c_a      <= r_a;
        r_c_b      <= r_b;
        r_c_result <= w_div_res_ext;
      end
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_result   = r_result;
  assign rsp_tag      = r_tag;
  assign div_start    = w_div_start;
  assign div_op       = r_op;
  assign div_is_word  = r_word;
  assign div_dividend = r_a;
  assign div_divisor  = r_b;

endmodule
